// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter in front of one shared add/subtract unit.
// The granted operation is computed combinationally and captured into a
// single-entry response buffer drained with a valid/ready handshake.
module addsub_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]     req_a,
   input  logic [NUM_REQ*WIDTH-1:0]     req_b,
   input  logic [NUM_REQ-1:0]           req_sub,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [WIDTH-1:0]             rsp_result,
   output logic                         rsp_carry,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id
);

   localparam int IDW = $clog2(NUM_REQ);

   // The buffer occupancy is the FSM state: EMPTY or FULL.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic [IDW-1:0]   id_q, id_d;

   logic [IDW-1:0]   gnt_idx;
   logic             gnt_found;
   logic             accept_en;
   logic             xfer;
   logic [WIDTH-1:0] a_sel, b_sel;
   logic             sub_sel;
   logic [WIDTH:0]   arith;

   // Index arithmetic modulo NUM_REQ; NUM_REQ need not be a power of two.
   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDW'(s);
   endfunction

   // Round-robin search: first valid requester at or after the pointer.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!gnt_found && req_valid[wrap_add(ptr_q, k)]) begin
            gnt_found = 1'b1;
            gnt_idx   = wrap_add(ptr_q, k);
         end
      end
   end

   // A new operation may enter when the buffer is empty or being drained now.
   // Gating with rst_n keeps every req_ready low while reset is held.
   always_comb begin
      accept_en = (state_q == EMPTY) || rsp_ready;
      xfer      = gnt_found && accept_en && rst_n;
   end

   // Steer the granted requester's operands into the shared unit.
   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      sub_sel = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            a_sel   = req_a[i*WIDTH +: WIDTH];
            b_sel   = req_b[i*WIDTH +: WIDTH];
            sub_sel = req_sub[i];
         end
      end
   end

   // WIDTH+1-bit unsigned add/sub; the top bit is carry for add, borrow for sub.
   always_comb begin
      if (sub_sel) arith = {1'b0, a_sel} - {1'b0, b_sel};
      else         arith = {1'b0, a_sel} + {1'b0, b_sel};
   end

   // Next-state logic for buffer occupancy.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (xfer) state_d = FULL;
         FULL:    if (rsp_ready && !xfer) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Payload and pointer only move on a transfer, so a stalled result stays put.
   always_comb begin
      result_d = result_q;
      carry_d  = carry_q;
      id_d     = id_q;
      ptr_d    = ptr_q;
      if (xfer) begin
         result_d = arith[WIDTH-1:0];
         carry_d  = arith[WIDTH];
         id_d     = gnt_idx;
         ptr_d    = wrap_add(gnt_idx, 1);
      end
   end

   // State and buffer registers; reset clears everything, including payload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         ptr_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         id_q     <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         id_q     <= id_d;
      end
   end

   // Outputs: one-hot accept strobe and the buffered response.
   always_comb begin
      req_ready = '0;
      if (xfer) req_ready[gnt_idx] = 1'b1;
      rsp_valid  = (state_q == FULL);
      rsp_result = result_q;
      rsp_carry  = carry_q;
      rsp_id     = id_q;
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed scenarios plus randomized traffic, checked by a
// predictor that queues expected responses and a monitor that consumes them.
module tb_addsub_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_sub;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_result;
   logic           rsp_carry;
   logic [1:0]     rsp_id;

   typedef struct {
      int res;
      int cry;
      int id;
   } rsp_t;

   rsp_t     exp_q[$];
   int       tests = 0;
   int       fails = 0;
   logic [N-1:0] last_acc;

   // Predictor state
   int mptr  = 0;
   bit mfull = 0;

   addsub_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_id     (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: compare the presented response against the oldest expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
         chk("rst_rsp_result", {24'd0, rsp_result}, 0);
         chk("rst_rsp_carry", {31'd0, rsp_carry}, 0);
         chk("rst_rsp_id", {30'd0, rsp_id}, 0);
         chk("rst_req_ready", {28'd0, req_ready}, 0);
         exp_q.delete();
      end else begin
         chk("rsp_valid", {31'd0, rsp_valid}, (exp_q.size() != 0) ? 1 : 0);
         if (rsp_valid && exp_q.size() != 0) begin
            chk("rsp_result", {24'd0, rsp_result}, exp_q[0].res);
            chk("rsp_carry", {31'd0, rsp_carry}, exp_q[0].cry);
            chk("rsp_id", {30'd0, rsp_id}, exp_q[0].id);
            if (rsp_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Predictor: decide the grant from the round-robin rule and queue the result.
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         mptr  = 0;
         mfull = 0;
      end else begin
         bit           acc_en;
         bit           found;
         int           g;
         int           a, b, s;
         logic [N-1:0] exp_rdy;
         rsp_t         e;
         acc_en  = !mfull || rsp_ready;
         found   = 0;
         g       = 0;
         for (int k = 0; k < N; k++) begin
            int i;
            i = (mptr + k) % N;
            if (!found && req_valid[i]) begin
               found = 1;
               g     = i;
            end
         end
         exp_rdy = '0;
         if (found && acc_en) exp_rdy[g] = 1'b1;
         chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
         if (found && acc_en) begin
            a = int'(req_a[g*W +: W]);
            b = int'(req_b[g*W +: W]);
            if (req_sub[g]) begin
               s     = a - b;
               e.res = (s + 256) % 256;
               e.cry = (a < b) ? 1 : 0;
            end else begin
               s     = a + b;
               e.res = s % 256;
               e.cry = (s > 255) ? 1 : 0;
            end
            e.id = g;
            exp_q.push_back(e);
            mptr = (g + 1) % N;
         end
         mfull = (found && acc_en) || (mfull && !rsp_ready);
      end
   end

   // Inputs are driven 2 time units after the rising edge; acceptance is read
   // in the low phase once req_ready has settled.
   task automatic tick();
      @(negedge clk);
      #2;
      last_acc = req_valid & req_ready;
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int i, input int a, input int b, input bit sub);
      req_a[i*W +: W] = W'(a);
      req_b[i*W +: W] = W'(b);
      req_sub[i]      = sub;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = 1'b0;

      // Reset held with random inputs
      for (int c = 0; c < 5; c++) begin
         req_valid = N'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
         req_sub   = N'($urandom);
         rsp_ready = 1'($urandom);
         tick();
         chk("rst_no_accept", {28'd0, last_acc}, 0);
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      rst_n     = 1'b1;
      tick();

      // Requester 0 add with carry out
      set_req(0, 200, 100, 1'b0);
      req_valid = 4'b0001;
      tick();
      chk("t2_grant", {28'd0, last_acc}, 1);
      req_valid = '0;
      chk("t2_result", {24'd0, rsp_result}, 44);
      chk("t2_carry", {31'd0, rsp_carry}, 1);
      chk("t2_id", {30'd0, rsp_id}, 0);

      // Requester 2 subtract, with and without borrow
      set_req(2, 5, 10, 1'b1);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      chk("t3_result_borrow", {24'd0, rsp_result}, 251);
      chk("t3_carry_borrow", {31'd0, rsp_carry}, 1);
      chk("t3_id", {30'd0, rsp_id}, 2);
      set_req(2, 10, 5, 1'b1);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      chk("t3_result", {24'd0, rsp_result}, 5);
      chk("t3_carry", {31'd0, rsp_carry}, 0);
      tick();

      // Bring the pointer back to 0 via a grant to requester 3
      set_req(3, 1, 2, 1'b0);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      tick();

      // All requesters valid: strict rotation, one grant per cycle
      for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         logic [N-1:0] exp_oh;
         exp_oh = '0;
         exp_oh[k % N] = 1'b1;
         tick();
         chk("t4_rotation", {28'd0, last_acc}, {28'd0, exp_oh});
      end

      // Stall: buffer full, consumer not ready, everything pending
      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t5_stall_no_grant", {28'd0, last_acc}, 0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("t5_release_grant", {28'd0, last_acc}, 4'b0100);

      // Reset pulse with a full buffer and pointer at 2
      req_valid = 4'b0010;
      tick();
      chk("t6_setup_grant", {28'd0, last_acc}, 4'b0010);
      rsp_ready = 1'b0;
      req_valid = 4'b1010;
      rst_n     = 1'b0;
      #1;
      chk("t6_async_drop", {31'd0, rsp_valid}, 0);
      tick();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      tick();
      chk("t6_ptr_reset", {28'd0, last_acc}, 4'b0010);
      req_valid = '0;
      tick();

      // Randomized traffic honouring the hold-until-accepted contract
      for (int c = 0; c < 400; c++) begin
         req_valid = req_valid & ~last_acc;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
               set_req(i, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
               req_valid[i] = 1'b1;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // Drain
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      chk("drain_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
